sobel_edge_stream: RTL and testbench
====================================

# sobel_edge_stream

Parametrised 3×3 Sobel edge-detection stage for the camera grayscale pixel stream. It sits after the Bayer-to-grayscale stage and in front of the RGB output mux. It replaces the fixed 12-bit, single-direction filter with configurable data width, line length, and a runtime mode: passthrough, horizontal, vertical or combined magnitude. It also adds frame-aware border handling, saturation and an optional threshold output.

## Interface
- `DW`, 12, pixel data width in bits.
- `LINE_W`, 640, valid pixels per line; the line-buffer depth.
- `CW`, $clog2(LINE_W), width of the column counter.

Ports (single clock; reset is asynchronous and active-low):
- `iCLK`  in  1  the only clock; all logic samples on its rising edge.
- `iRST`  in  1  asynchronous active-low reset.
- `iDATA`  in  DW  grayscale pixel.
- `iDVAL`  in  1  `iDATA` valid this cycle.
- `iSOF`  in  1  qualified by `iDVAL`; marks the first pixel of a frame.
- `iMODE`  in  2  00 passthrough, 01 vertical-edge (GV), 10 horizontal-edge (GH), 11 magnitude.
- `iTHRESH`  in  DW  edge threshold.
- `oDATA`  out  DW  filtered pixel.
- `oDVAL`  out  1  `oDATA` valid.
- `oEDGE`  out  1  `oDATA` >= `iTHRESH`; qualified by `oDVAL`.

## Operation
- An accepted pixel is one with `iDVAL`=1. Only accepted pixels advance the column/row counters, the line buffers and the window. Cycles with `iDVAL`=0 change none of them.
- Column counter `col`:
  - increments per accepted pixel;
  - wraps from LINE_W-1 to 0;
  - on each wrap, the row counter `row` increments and saturates at 2.
- `iSOF`=1 on an accepted pixel forces that pixel to position (0,0), including mid-frame. The line-buffer contents are not cleared; border masking hides the stale rows.
- Line buffer: two cascaded LINE_W-deep delays give the column above and the column two rows above the current pixel.
- Window: 3×3 shift registers `w[r][c]`, where r=0 is the oldest row and c=0 the oldest column. On acceptance each row shifts left and takes a new rightmost element.
- Each accepted pixel produces exactly one output, for the window centre `w[1][1]`, i.e. the input position (row-1, col-1).
- Filters:
  - GV = (w02 + 2·w12 + w22) − (w00 + 2·w10 + w20)
  - GH = (w20 + 2·w21 + w22) − (w00 + 2·w01 + w02)
  - Both are signed, DW+3 bits, with no intermediate truncation.
- Result by mode:
  - 01: |GV|
  - 10: |GH|
  - 11: |GV| + |GH|, computed at DW+3 bits
  - 00: `w[1][1]` unmodified
- In modes 01/10/11 the result saturates to 2^DW−1 when it exceeds DW bits.
- Border: in modes 01/10/11, output is 0 when the accepted pixel's row < 2 or col < 2. Passthrough is never masked.
- `iMODE` and `iTHRESH` are captured together with each accepted pixel and travel down the pipeline with it. A mode change mid-line therefore affects only later pixels.

## Timing
- Pipeline stages, each one clock:
  - S1: window and line-buffer update; capture mode, threshold and border flag.
  - S2: GV/GH sums.
  - S3: absolute value, magnitude, saturation, mux, threshold compare; drives the registered outputs.
- Latency: `oDVAL` rises exactly 3 clocks after the accepted `iDVAL`. Stages advance every clock with a valid tag, so input gaps are reproduced unchanged at the output.
- Throughput: one pixel per clock; there is no back-pressure.
- Reset (`iRST`=0, asynchronous): `oDATA`=0, `oDVAL`=0, `oEDGE`=0, counters 0, window and valid tags 0. Line-buffer RAM is not cleared.
- Reset asserted mid-frame: outputs go low immediately. The first accepted pixel after release is treated as (0,0), whether or not `iSOF` is set.
- `iSOF` coincident with the column wrap: `iSOF` wins, giving (0,0) with row=0.

## Configuration
- `SOBEL_THRESH_EN` defined:
  - comparator present;
  - `iTHRESH` pipelined;
  - `oEDGE` = (`oDATA` >= threshold) for mode ≠ 00, and 0 in mode 00.
- `SOBEL_THRESH_EN` undefined: comparator and threshold pipeline removed, `iTHRESH` ignored, `oEDGE` tied to 0.

## Structure
- Package `sobel_pkg`: mode encodings (MODE_PASS, MODE_GV, MODE_GH, MODE_MAG) and the default DW/LINE_W constants.
- Sub-module `sobel_line_buf`, parametrised by DW and LINE_W:
  - clock-enabled two-tap shift delay;
  - inputs: `clken` and `shiftin`;
  - outputs: `tap1` (one line back) and `tap2` (two lines back).

## Test plan
Bench uses DW=12, LINE_W=8.
- Reset: hold `iRST`=0 while streaming data -> `oDATA`=0, `oDVAL`=0, `oEDGE`=0 throughout.
- Flat frame of 0x800, mode 11, continuous `iDVAL` -> every output 0x000. `oDVAL` count equals input count, and the first `oDVAL` comes 3 clocks after the first `iDVAL`.
- Vertical step (cols 0–3 = 0, cols 4–7 = 0x100), mode 01 -> output 0x400 for rows ≥2 at the outputs of input cols 4 and 5, 0 elsewhere. Same input in mode 10 -> all 0.
- Saturation: horizontal step 0 -> 0xFFF between rows 3 and 4, mode 11 -> 0xFFF at the edge rows, never a wrapped value. With `SOBEL_THRESH_EN` and `iTHRESH`=0x800, `oEDGE`=1 exactly there.
- Gaps and resync: random `iDVAL` deasserts plus an `iSOF` at col 5 of row 3 -> output sequence identical to the gap-free reference. The next two rows after `iSOF` output 0 in mode 11.
- Mode 00 with a ramp input -> `oDATA` equals the input delayed by LINE_W+1 accepted pixels, including border rows.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared encodings and default sizing for the Sobel edge-detection stage.
package sobel_pkg;

    localparam int SOBEL_DW     = 12;
    localparam int SOBEL_LINE_W = 640;

    typedef enum logic [1:0] {
        MODE_PASS = 2'b00,
        MODE_GV   = 2'b01,
        MODE_GH   = 2'b10,
        MODE_MAG  = 2'b11
    } sobel_mode_e;

endpackage

// File: rtl/sobel_line_buf.sv
// Two cascaded LINE_W-deep pixel delays advancing only on clken; the storage has no reset.
module sobel_line_buf #(
    parameter int DW     = 12,
    parameter int LINE_W = 640
) (
    input  logic          iCLK,
    input  logic          clken,
    input  logic [DW-1:0] shiftin,
    output logic [DW-1:0] tap1,
    output logic [DW-1:0] tap2
);

    logic [DW-1:0] r_d1 [LINE_W];
    logic [DW-1:0] r_d2 [LINE_W];

    always_ff @(posedge iCLK) begin
        if (clken) begin
            r_d1[0] <= shiftin;
            r_d2[0] <= r_d1[LINE_W-1];
            for (int i = 1; i < LINE_W; i++) begin
                r_d1[i] <= r_d1[i-1];
                r_d2[i] <= r_d2[i-1];
            end
        end
    end

    assign tap1 = r_d1[LINE_W-1];
    assign tap2 = r_d2[LINE_W-1];

endmodule

// File: rtl/sobel_edge_stream.sv
// Three-stage 3x3 Sobel filter on a grayscale pixel stream with border masking and saturation.
// Define SOBEL_THRESH_EN to build the threshold comparator driving oEDGE.
module sobel_edge_stream
    import sobel_pkg::*;
#(
    parameter int DW     = SOBEL_DW,
    parameter int LINE_W = SOBEL_LINE_W,
    parameter int CW     = $clog2(LINE_W)
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic [DW-1:0] iDATA,
    input  logic          iDVAL,
    input  logic          iSOF,
    input  logic [1:0]    iMODE,
    input  logic [DW-1:0] iTHRESH,
    output logic [DW-1:0] oDATA,
    output logic          oDVAL,
    output logic          oEDGE
);

    localparam int SW = DW + 3;

    logic [CW-1:0] r_col, w_col;
    logic [1:0]    r_row, w_row;
    logic          w_last;
    logic [DW-1:0] w_tap1, w_tap2;
    logic [DW-1:0] r_win [3][3];
    logic          r_v1, r_border1;
    sobel_mode_e   r_mode1;

    logic signed [SW-1:0] w_gv, w_gh, r_gv, r_gh;
    logic                 r_v2, r_border2;
    sobel_mode_e          r_mode2;
    logic [DW-1:0]        r_pass2;

    logic [SW-1:0] w_agv, w_agh, w_res;
    logic [DW-1:0] w_out;

    sobel_line_buf #(.DW(DW), .LINE_W(LINE_W)) u_line_buf (
        .iCLK    (iCLK),
        .clken   (iDVAL),
        .shiftin (iDATA),
        .tap1    (w_tap1),
        .tap2    (w_tap2)
    );

    // SOF overrides the running position, including a coincident column wrap.
    always_comb begin
        w_col  = iSOF ? '0 : r_col;
        w_row  = iSOF ? 2'd0 : r_row;
        w_last = (w_col == CW'(LINE_W - 1));
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_col     <= '0;
            r_row     <= 2'd0;
            r_v1      <= 1'b0;
            r_border1 <= 1'b0;
            r_mode1   <= MODE_PASS;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    r_win[r][c] <= '0;
        end else begin
            r_v1 <= iDVAL;
            if (iDVAL) begin
                r_col     <= w_last ? '0 : w_col + CW'(1);
                r_row     <= (w_last && w_row != 2'd2) ? w_row + 2'd1 : w_row;
                r_border1 <= (w_row < 2'd2) || (w_col < CW'(2));
                r_mode1   <= sobel_mode_e'(iMODE);
                for (int r = 0; r < 3; r++) begin
                    r_win[r][0] <= r_win[r][1];
                    r_win[r][1] <= r_win[r][2];
                end
                r_win[0][2] <= w_tap2;
                r_win[1][2] <= w_tap1;
                r_win[2][2] <= iDATA;
            end
        end
    end

    function automatic logic [SW-1:0] tri_sum(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [DW-1:0] c);
        return SW'(a) + (SW'(b) << 1) + SW'(c);
    endfunction

    always_comb begin
        w_gv = signed'(tri_sum(r_win[0][2], r_win[1][2], r_win[2][2]))
             - signed'(tri_sum(r_win[0][0], r_win[1][0], r_win[2][0]));
        w_gh = signed'(tri_sum(r_win[2][0], r_win[2][1], r_win[2][2]))
             - signed'(tri_sum(r_win[0][0], r_win[0][1], r_win[0][2]));
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_v2      <= 1'b0;
            r_gv      <= '0;
            r_gh      <= '0;
            r_border2 <= 1'b0;
            r_mode2   <= MODE_PASS;
            r_pass2   <= '0;
        end else begin
            r_v2      <= r_v1;
            r_gv      <= w_gv;
            r_gh      <= w_gh;
            r_border2 <= r_border1;
            r_mode2   <= r_mode1;
            r_pass2   <= r_win[1][1];
        end
    end

    // Magnitude sum of two DW+2-bit absolutes cannot overflow SW bits.
    always_comb begin
        w_agv = r_gv[SW-1] ? unsigned'(-r_gv) : unsigned'(r_gv);
        w_agh = r_gh[SW-1] ? unsigned'(-r_gh) : unsigned'(r_gh);
        case (r_mode2)
            MODE_GV:  w_res = w_agv;
            MODE_GH:  w_res = w_agh;
            MODE_MAG: w_res = w_agv + w_agh;
            default:  w_res = '0;
        endcase
        if (r_mode2 == MODE_PASS)
            w_out = r_pass2;
        else if (r_border2)
            w_out = '0;
        else if (|w_res[SW-1:DW])
            w_out = '1;
        else
            w_out = w_res[DW-1:0];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oDATA <= '0;
            oDVAL <= 1'b0;
        end else begin
            oDVAL <= r_v2;
            if (r_v2)
                oDATA <= w_out;
        end
    end

`ifdef SOBEL_THRESH_EN
    logic [DW-1:0] r_thr1, r_thr2;
    logic          r_edge;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_thr1 <= '0;
            r_thr2 <= '0;
            r_edge <= 1'b0;
        end else begin
            if (iDVAL)
                r_thr1 <= iTHRESH;
            r_thr2 <= r_thr1;
            r_edge <= r_v2 && (r_mode2 != MODE_PASS) && (w_out >= r_thr2);
        end
    end

    assign oEDGE = r_edge;
`else
    logic w_unused_thresh;
    assign w_unused_thresh = ^iTHRESH;
    assign oEDGE = 1'b0;
`endif

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Randomized scoreboard bench for sobel_edge_stream; expected pixels come from a frame-image model.
module tb_sobel_edge_stream;

    localparam int DW = 12;
    localparam int LW = 8;
    localparam int MAXV = (1 << DW) - 1;

    logic          iCLK, iRST, iDVAL, iSOF;
    logic [DW-1:0] iDATA, iTHRESH, oDATA;
    logic [1:0]    iMODE;
    logic          oDVAL, oEDGE;

    sobel_edge_stream #(.DW(DW), .LINE_W(LW)) dut (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iDATA   (iDATA),
        .iDVAL   (iDVAL),
        .iSOF    (iSOF),
        .iMODE   (iMODE),
        .iTHRESH (iTHRESH),
        .oDATA   (oDATA),
        .oDVAL   (oDVAL),
        .oEDGE   (oEDGE)
    );

    typedef struct {
        int data;
        bit edge_v;
        bit dc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   ecount = 0;
    int   n_out = 0;
    int   first_out = -1;
    int   m_line, m_col;
    int   m_img [4][LW];
    int   m_hist[$];

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    always @(posedge iCLK) ecount++;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    exp_t mon_e;
    always @(negedge iCLK) begin
        if (iRST && oDVAL) begin
            n_out++;
            if (first_out < 0) first_out = ecount;
            if (sb.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                if (!mon_e.dc) chk("data", int'(oDATA), mon_e.data);
                chk("edge", int'(oEDGE), int'(mon_e.edge_v));
            end
        end
    end

    function automatic int px(input int r, input int c);
        return m_img[(m_line - 2 + r) % 4][m_col - 2 + c];
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_line = 0;
        m_col = 0;
        m_hist.delete();
        n_out = 0;
        first_out = -1;
    endtask

    task automatic send(input int d, input bit sof, input int mode, input int thr);
        exp_t e;
        int gv, gh, res, k;
        iDATA = DW'(d); iSOF = sof; iMODE = 2'(mode); iTHRESH = DW'(thr); iDVAL = 1'b1;
        if (sof) begin
            m_line = 0;
            m_col = 0;
        end
        m_img[m_line % 4][m_col] = d;
        m_hist.push_back(d);
        e.dc = 1'b0;
        if (mode == 0) begin
            k = m_hist.size() - 1;
            e.dc = (k < LW + 1);
            res = e.dc ? 0 : m_hist[k - LW - 1];
        end else if (m_line < 2 || m_col < 2) begin
            res = 0;
        end else begin
            gv = (px(0,2) + 2*px(1,2) + px(2,2)) - (px(0,0) + 2*px(1,0) + px(2,0));
            gh = (px(2,0) + 2*px(2,1) + px(2,2)) - (px(0,0) + 2*px(0,1) + px(0,2));
            res = (mode == 1) ? iabs(gv) : (mode == 2) ? iabs(gh) : iabs(gv) + iabs(gh);
            if (res > MAXV) res = MAXV;
        end
        e.data = res;
`ifdef SOBEL_THRESH_EN
        e.edge_v = (mode != 0) && (res >= thr);
`else
        e.edge_v = 1'b0;
`endif
        sb.push_back(e);
        m_col++;
        if (m_col == LW) begin
            m_col = 0;
            m_line++;
        end
        @(posedge iCLK); #1;
        iDVAL = 1'b0;
        iSOF = 1'b0;
    endtask

    task automatic idle(input int n);
        iDVAL = 1'b0;
        repeat (n) begin
            @(posedge iCLK); #1;
        end
    endtask

    initial begin
        int start;
        iRST = 1'b0; iDVAL = 1'b0; iSOF = 1'b0; iMODE = 2'd0;
        iDATA = '0; iTHRESH = '0;
        m_line = 0; m_col = 0;
        @(posedge iCLK); #1;

        // reset held while data streams
        repeat (12) begin
            iDATA = DW'($urandom); iDVAL = 1'b1; iMODE = 2'd3; iSOF = 1'($urandom);
            @(negedge iCLK);
            chk("rst_data", int'(oDATA), 0);
            chk("rst_dval", int'(oDVAL), 0);
            chk("rst_edge", int'(oEDGE), 0);
            @(posedge iCLK); #1;
        end
        iDVAL = 1'b0; iSOF = 1'b0;
        iRST = 1'b1;
        model_reset();
        idle(2);

        // flat frame, magnitude mode
        start = ecount;
        for (int i = 0; i < 6*LW; i++) send(12'h800, i == 0, 3, $urandom_range(1, MAXV));
        idle(6);
        chk("latency", first_out, start + 3);
        chk("out_count", n_out, 6*LW);

        // vertical step in GV then GH
        for (int m = 1; m <= 2; m++)
            for (int i = 0; i < 6*LW; i++)
                send((i % LW) >= 4 ? 12'h100 : 0, i == 0, m, $urandom_range(1, MAXV));
        idle(6);

        // horizontal full-scale step for saturation
        for (int i = 0; i < 7*LW; i++) send((i / LW) >= 4 ? MAXV : 0, i == 0, 3, 12'h800);
        idle(6);

        // gaps plus mid-frame SOF at row 3 col 5
        for (int i = 0; i < 6*LW + 5; i++) begin
            send($urandom_range(0, MAXV), (i == 0) || (i == 3*LW + 5), 3, $urandom_range(1, MAXV));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(6);

        // random modes, thresholds, gaps and occasional SOF
        for (int i = 0; i < 120; i++) begin
            send($urandom_range(0, MAXV), (i == 0) || ($urandom_range(0, 39) == 0),
                 $urandom_range(0, 3), $urandom_range(0, MAXV));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(6);

        // passthrough ramp
        for (int i = 0; i < 4*LW; i++) send((i * 37) & MAXV, i == 0, 0, $urandom_range(0, MAXV));
        idle(6);

        // asynchronous reset mid-frame with results in flight
        for (int i = 0; i < 10; i++) send($urandom_range(0, MAXV), 1'b0, 3, $urandom_range(1, MAXV));
        #2;
        iRST = 1'b0;
        sb.delete();
        #1;
        chk("midrst_data", int'(oDATA), 0);
        chk("midrst_dval", int'(oDVAL), 0);
        chk("midrst_edge", int'(oEDGE), 0);
        @(posedge iCLK); #1;
        iRST = 1'b1;
        model_reset();
        for (int i = 0; i < 4*LW; i++)
            send($urandom_range(0, MAXV), 1'b0, $urandom_range(1, 3), $urandom_range(1, MAXV));
        idle(6);
        chk("post_rst_count", n_out, 4*LW);

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
